// File: rtl/alu_div_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_div_sequencer                                             |
// | Brief    : Iterative restoring divider that borrows the shared datapath  |
// |            ALU for every compare/subtract. Optional DIV_SIGNED_EN adds   |
// |            signed division with post-negation steps.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [2:0]       alu_control,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SHIFT = 3'd1;
    localparam logic [2:0] c_ST_CMP   = 3'd2;
    localparam logic [2:0] c_ST_SUB   = 3'd3;
    localparam logic [2:0] c_ST_FIN   = 3'd4;
`ifdef DIV_SIGNED_EN
    localparam logic [2:0] c_ST_NEG_Q = 3'd5;
    localparam logic [2:0] c_ST_NEG_R = 3'd6;
`endif

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH);

    logic [2:0]       r_state, w_state_nxt, w_after_iter;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_quo, w_quo_nxt;
    logic [WIDTH-1:0] r_dvs, w_dvs_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [WIDTH-1:0] r_quotient, w_quotient_nxt;
    logic [WIDTH-1:0] r_remainder, w_remainder_nxt;
    logic             r_dbz, w_dbz_nxt;
`ifdef DIV_SIGNED_EN
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_quo       <= w_quo_nxt;
            r_dvs       <= w_dvs_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ovf       <= w_ovf_nxt;
            r_quotient  <= w_quotient_nxt;
            r_remainder <= w_remainder_nxt;
            r_dbz       <= w_dbz_nxt;
`ifdef DIV_SIGNED_EN
            r_neg_q     <= w_neg_q_nxt;
            r_neg_r     <= w_neg_r_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_quo_nxt       = r_quo;
        w_dvs_nxt       = r_dvs;
        w_cnt_nxt       = r_cnt;
        w_ovf_nxt       = r_ovf;
        w_quotient_nxt  = r_quotient;
        w_remainder_nxt = r_remainder;
        w_dbz_nxt       = r_dbz;
        alu_control     = c_ALU_ADD;
        alu_a           = '0;
        alu_b           = '0;
`ifdef DIV_SIGNED_EN
        w_neg_q_nxt     = r_neg_q;
        w_neg_r_nxt     = r_neg_r;
`endif

        // r_cnt was already decremented in SHIFT, so zero here means last bit.
        if (r_cnt != '0)
            w_after_iter = c_ST_SHIFT;
`ifdef DIV_SIGNED_EN
        else if (r_neg_q)
            w_after_iter = c_ST_NEG_Q;
        else if (r_neg_r)
            w_after_iter = c_ST_NEG_R;
`endif
        else
            w_after_iter = c_ST_FIN;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        w_state_nxt     = c_ST_FIN;
                        w_quotient_nxt  = '1;
                        w_remainder_nxt = dividend;
                        w_dbz_nxt       = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_SHIFT;
                        w_rem_nxt   = '0;
                        w_quo_nxt   = dividend;
                        w_dvs_nxt   = divisor;
                        w_cnt_nxt   = c_CNT_INIT;
                        w_ovf_nxt   = 1'b0;
                        w_dbz_nxt   = 1'b0;
`ifdef DIV_SIGNED_EN
                        w_neg_q_nxt = 1'b0;
                        w_neg_r_nxt = 1'b0;
                        if (signed_op) begin
                            w_neg_q_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            w_neg_r_nxt = dividend[WIDTH-1];
                            if (dividend[WIDTH-1]) w_quo_nxt = -dividend;
                            if (divisor[WIDTH-1])  w_dvs_nxt = -divisor;
                        end
`endif
                    end
                end
            end
            c_ST_SHIFT: begin
                {w_ovf_nxt, w_rem_nxt, w_quo_nxt} = {r_rem, r_quo, 1'b0};
                w_cnt_nxt   = r_cnt - CNT_W'(1);
                w_state_nxt = c_ST_CMP;
            end
            c_ST_CMP: begin
                alu_control = c_ALU_SLT;
                alu_a       = r_rem;
                alu_b       = r_dvs;
                // A shifted-out bit means the partial remainder exceeds any divisor.
                if (r_ovf || alu_zero)
                    w_state_nxt = c_ST_SUB;
                else
                    w_state_nxt = w_after_iter;
            end
            c_ST_SUB: begin
                alu_control  = c_ALU_SUB;
                alu_a        = r_rem;
                alu_b        = r_dvs;
                w_rem_nxt    = alu_result;
                w_quo_nxt[0] = 1'b1;
                w_state_nxt  = w_after_iter;
            end
`ifdef DIV_SIGNED_EN
            c_ST_NEG_Q: begin
                alu_control = c_ALU_SUB;
                alu_b       = r_quo;
                w_quo_nxt   = alu_result;
                w_state_nxt = r_neg_r ? c_ST_NEG_R : c_ST_FIN;
            end
            c_ST_NEG_R: begin
                alu_control = c_ALU_SUB;
                alu_b       = r_rem;
                w_rem_nxt   = alu_result;
                w_state_nxt = c_ST_FIN;
            end
`endif
            c_ST_FIN: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Results land on entry to FIN so they are valid while done is high.
        if ((w_state_nxt == c_ST_FIN) && (r_state != c_ST_IDLE) && (r_state != c_ST_FIN)) begin
            w_quotient_nxt  = w_quo_nxt;
            w_remainder_nxt = w_rem_nxt;
        end
    end

    assign busy        = (r_state != c_ST_IDLE) && (r_state != c_ST_FIN);
    assign done        = (r_state == c_ST_FIN);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_div_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_div_sequencer                                          |
// | Brief    : Self-checking bench for alu_div_sequencer with a local ALU    |
// |            model and an arithmetic reference (DIV_SIGNED_EN aware).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_drv;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    logic [2:0]  alu_control;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;

    int n_checks;
    int n_fail;
    int alu_idle_viol;

    always #5 clk = ~clk;

    alu_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef DIV_SIGNED_EN
        .signed_op   (signed_drv),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .alu_control (alu_control),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    // Shared datapath ALU; SLT compares magnitudes so alu_zero means a >= b.
    always_comb begin
        alu_result = 32'h0;
        case (alu_control)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            3'b111:  alu_result = {31'h0, (alu_a < alu_b)};
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    // The ALU must sit at ADD 0,0 whenever the sequencer does not own it.
    always @(negedge clk) begin
        if (!busy && (alu_control !== 3'b010 || alu_a !== 32'h0 || alu_b !== 32'h0))
            alu_idle_viol++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sop,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dbz, output int lat);
        logic [31:0] ua, ub, uq, ur;
        logic        nq, nr;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF; r = a; dbz = 1'b1; lat = 1;
            return;
        end
        ua = a; ub = b; nq = 1'b0; nr = 1'b0;
        if (sop) begin
            nr = a[31];
            nq = a[31] ^ b[31];
            if (a[31]) ua = -a;
            if (b[31]) ub = -b;
        end
        uq  = ua / ub;
        ur  = ua % ub;
        q   = nq ? -uq : uq;
        r   = nr ? -ur : ur;
        dbz = 1'b0;
        lat = 65 + $countones(uq) + int'(nq) + int'(nr);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_q"}, quotient, 0);
        check({tag, "_r"}, remainder, 0);
        check({tag, "_dbz"}, div_by_zero, 0);
        check({tag, "_aluc"}, alu_control, 32'd2);
        check({tag, "_alua"}, alu_a, 0);
        check({tag, "_alub"}, alu_b, 0);
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sop,
                           input int inject_cyc, input int rst_cyc,
                           input logic start_at_done, input string tag);
        logic [31:0] eq, er;
        logic        edbz, seen, saw_done;
        int          elat, n, busy_cnt;
        model(a, b, sop, eq, er, edbz, elat);
        dividend = a; divisor = b; signed_drv = sop; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; busy_cnt = 0; seen = 1'b0;
        while (n <= 200) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (n == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check_reset({tag, "_rst"});
                @(posedge clk); #1;
                rst_n = 1'b1;
                saw_done = 1'b0;
                repeat (6) begin
                    @(posedge clk); #1;
                    if (done) saw_done = 1'b1;
                end
                check({tag, "_nodone"}, saw_done, 0);
                check({tag, "_idle"}, busy, 0);
                return;
            end
            if (n == inject_cyc) begin
                dividend = 32'd9; divisor = 32'd3; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check({tag, "_seen"}, seen, 1);
        check({tag, "_lat"}, n, elat);
        check({tag, "_busycyc"}, busy_cnt, elat - 1);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, edbz);
        if (start_at_done) begin
            dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_pulse"}, done, 0);
        check({tag, "_not_restarted"}, busy, 0);
        check({tag, "_q_hold"}, quotient, eq);
        check({tag, "_r_hold"}, remainder, er);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        n_checks = 0; n_fail = 0; alu_idle_viol = 0;
        rst_n = 1'b0; start = 1'b0; signed_drv = 1'b0;
        dividend = 32'h0; divisor = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_div(32'd100, 32'd7, 1'b0, -1, -1, 1'b0, "d100_7");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, -1, -1, 1'b0, "dmax_1");
        run_div(32'd1234, 32'd0, 1'b0, -1, -1, 1'b1, "dz_1234");
        check("alu_idle_dz", alu_idle_viol, 0);
        run_div(32'd100, 32'd7, 1'b0, 10, -1, 1'b0, "ign_start");
        run_div(32'd100, 32'd7, 1'b0, -1, 20, 1'b0, "rst_mid");
        run_div(32'd9, 32'd3, 1'b0, -1, -1, 1'b0, "after_rst");
        run_div(32'd5, 32'd9, 1'b0, -1, -1, 1'b1, "small_div");
        run_div(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, -1, -1, 1'b0, "big_dvs");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = $urandom >> $urandom_range(0, 31);
                2:       rb = $urandom_range(1, 16);
                default: rb = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'hFFFF);
            endcase
            run_div(ra, rb, 1'b0, -1, -1, 1'($urandom_range(0, 1)), "rand_u");
        end

`ifdef DIV_SIGNED_EN
        run_div(-32'sd7, 32'd2, 1'b1, -1, -1, 1'b0, "s_m7_2");
        check("s_m7_2_q_lit", quotient, 32'hFFFF_FFFD);
        check("s_m7_2_r_lit", remainder, 32'hFFFF_FFFF);
        run_div(32'd7, -32'sd2, 1'b1, -1, -1, 1'b0, "s_7_m2");
        check("s_7_m2_q_lit", quotient, 32'hFFFF_FFFD);
        check("s_7_m2_r_lit", remainder, 32'd1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1, 1'b0, "s_min_m1");
        check("s_min_m1_q_lit", quotient, 32'h8000_0000);
        run_div(-32'sd100, 32'd0, 1'b1, -1, -1, 1'b0, "s_dz");
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run_div(ra, rb, rs, -1, -1, 1'b0, "rand_s");
        end
`endif

        check("alu_idle_all", alu_idle_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
